result_buffer_ctrl: RTL and testbench

Parametrised address and occupancy controller for the CNN result buffer: it generates write and read pointers into a DEPTH-entry result RAM from independent write/read strobes. It is the next generation of the result address counter. Generalisations:
- arbitrary depth;
- simultaneous read and write in one cycle;
- full/empty/almost-full flags, occupancy count and sticky error flags;
- synchronous flush.

It sits between the layer output stage (writer) and the result readout/classifier stage (reader).

---
 rtl/result_buf_pkg.sv | 20 ++
 rtl/result_buffer_ctrl_wrap_counter.sv | 38 +++
 rtl/result_buffer_ctrl.sv | 102 ++++++++++
 tb/tb_result_buffer_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_buf_pkg.sv
// rtl/result_buf_pkg.sv - shared constants, types and width helper for result buffer controllers
package result_buf_pkg;

  localparam int RESULT_DEPTH_DEFAULT = 14;
  localparam int RESULT_AF_DEFAULT    = 12;

  typedef struct packed {
    logic wr;
    logic rd;
  } acc_t;

  // Address width for an n-entry buffer: max(1, clog2(n)), usable in constant context.
  function automatic int addr_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/result_buffer_ctrl_wrap_counter.sv
// rtl/result_buffer_ctrl_wrap_counter.sv - mod-MOD pointer counter with synchronous clear
module wrap_counter
  import result_buf_pkg::*;
#(
  parameter int MOD = RESULT_DEPTH_DEFAULT,
  localparam int W  = addr_width(MOD)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Wrap at MOD-1 rather than at 2^W so non-power-of-two depths never leave the RAM range.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (en) begin
      value_d = (value_q == W'(MOD - 1)) ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/result_buffer_ctrl.sv
// rtl/result_buffer_ctrl.sv - result RAM pointer, occupancy and error-flag controller
module result_buffer_ctrl
  import result_buf_pkg::*;
#(
  parameter int DEPTH    = RESULT_DEPTH_DEFAULT,
  parameter int AF_LEVEL = RESULT_AF_DEFAULT,
  localparam int AW      = addr_width(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write_en,
  input  logic          read_en,
  input  logic          flush,
  output logic [AW-1:0] in_address,
  output logic [AW-1:0] out_address,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          overflow,
  output logic          underflow
);

  acc_t          acc;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  // Acceptance looks only at registered flags, so a read never rescues a write into a full buffer.
  assign acc.wr = write_en & ~full_q;
  assign acc.rd = read_en & ~empty_q;

  wrap_counter #(.MOD(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .en    (acc.wr),
    .value (in_address)
  );

  wrap_counter #(.MOD(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .en    (acc.rd),
    .value (out_address)
  );

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q | (write_en & full_q);
    underflow_d = underflow_q | (read_en & empty_q);
    if (flush) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      case ({acc.wr, acc.rd})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Flags derive from the next count so they switch on the same edge as count itself.
  always_comb begin
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CW'(AF_LEVEL));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_result_buffer_ctrl.sv
// tb/tb_result_buffer_ctrl.sv - self-checking bench for result_buffer_ctrl at DEPTH 14 and 16
module tb_result_buffer_ctrl;

  localparam int D = 14;
  localparam int AF = 12;

  logic clk = 1'b0;
  logic reset;
  logic write_en, read_en, flush;
  logic [3:0] in_address, out_address;
  logic [3:0] count;
  logic full, empty, almost_full, overflow, underflow;

  logic write_en16;
  logic [3:0] in_address16, out_address16;
  logic [4:0] count16;
  logic full16, empty16, af16, ovf16, udf16;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int   in_a;
    int   out_a;
    int   cnt;
    logic full;
    logic empty;
    logic af;
    logic ovf;
    logic udf;
  } exp_t;

  typedef struct {
    logic we;
    logic re;
    logic fl;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  int   m_in, m_out, m_cnt;
  logic m_ovf, m_udf;

  always #5 clk = ~clk;

  result_buffer_ctrl #(.DEPTH(D), .AF_LEVEL(AF)) dut14 (
    .clk         (clk),
    .reset       (reset),
    .write_en    (write_en),
    .read_en     (read_en),
    .flush       (flush),
    .in_address  (in_address),
    .out_address (out_address),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  result_buffer_ctrl #(.DEPTH(16), .AF_LEVEL(12)) dut16 (
    .clk         (clk),
    .reset       (reset),
    .write_en    (write_en16),
    .read_en     (1'b0),
    .flush       (1'b0),
    .in_address  (in_address16),
    .out_address (out_address16),
    .count       (count16),
    .full        (full16),
    .empty       (empty16),
    .almost_full (af16),
    .overflow    (ovf16),
    .underflow   (udf16)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".in_address"}, int'(in_address), e.in_a);
    chk({tag, ".out_address"}, int'(out_address), e.out_a);
    chk({tag, ".count"}, int'(count), e.cnt);
    chk({tag, ".full"}, int'(full), int'(e.full));
    chk({tag, ".empty"}, int'(empty), int'(e.empty));
    chk({tag, ".almost_full"}, int'(almost_full), int'(e.af));
    chk({tag, ".overflow"}, int'(overflow), int'(e.ovf));
    chk({tag, ".underflow"}, int'(underflow), int'(e.udf));
  endtask

  function automatic void model_clear();
    m_in = 0; m_out = 0; m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
  endfunction

  function automatic exp_t model_step(input logic we, input logic re, input logic fl);
    exp_t e;
    logic wa, ra;
    wa = we && (m_cnt != D);
    ra = re && (m_cnt != 0);
    if (fl) begin
      model_clear();
    end else begin
      if (we && m_cnt == D) m_ovf = 1'b1;
      if (re && m_cnt == 0) m_udf = 1'b1;
      if (wa) m_in = (m_in + 1) % D;
      if (ra) m_out = (m_out + 1) % D;
      m_cnt = m_cnt + int'(wa) - int'(ra);
    end
    e.in_a = m_in; e.out_a = m_out; e.cnt = m_cnt;
    e.full = (m_cnt == D); e.empty = (m_cnt == 0); e.af = (m_cnt >= AF);
    e.ovf = m_ovf; e.udf = m_udf;
    return e;
  endfunction

  // Expectation is queued as stimulus is driven and retired once the edge has landed.
  task automatic step(input logic we, input logic re, input logic fl, input string tag);
    exp_t e;
    sb.push_back(model_step(we, re, fl));
    write_en = we; read_en = re; flush = fl;
    @(posedge clk); #1;
    write_en = 1'b0; read_en = 1'b0; flush = 1'b0;
    e = sb.pop_front();
    chk_all(tag, e);
  endtask

  initial begin
    exp_t z;
    z = '{0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    vecs[0] = '{1'b1, 1'b0, 1'b0, '{1, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{1'b1, 1'b1, 1'b0, '{2, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[2] = '{1'b0, 1'b1, 1'b0, '{2, 2, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[3] = '{1'b0, 1'b1, 1'b0, '{2, 2, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[4] = '{1'b1, 1'b1, 1'b0, '{3, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[5] = '{1'b1, 1'b0, 1'b1, '{0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[6] = '{1'b0, 1'b1, 1'b1, '{0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};

    write_en = 1'b0; read_en = 1'b0; flush = 1'b0; write_en16 = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    chk_all("reset", z);

    for (int i = 0; i < 7; i++) begin
      void'(model_step(vecs[i].we, vecs[i].re, vecs[i].fl));
      write_en = vecs[i].we; read_en = vecs[i].re; flush = vecs[i].fl;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e);
    end
    write_en = 1'b0; read_en = 1'b0; flush = 1'b0;

    // Fill to full, then one write too many.
    for (int i = 0; i < D; i++) begin
      chk($sformatf("fill.pre_in%0d", i), int'(in_address), i);
      step(1'b1, 1'b0, 1'b0, $sformatf("fill%0d", i));
      chk($sformatf("fill.af%0d", i), int'(almost_full), int'(i >= AF - 1));
    end
    chk("fill.full", int'(full), 1);
    chk("fill.count", int'(count), D);
    step(1'b1, 1'b0, 1'b0, "fill.extra");
    chk("fill.extra_in", int'(in_address), 0);
    chk("fill.extra_ovf", int'(overflow), 1);

    for (int i = 0; i < D; i++) begin
      chk($sformatf("drain.pre_out%0d", i), int'(out_address), i);
      step(1'b0, 1'b1, 1'b0, $sformatf("drain%0d", i));
    end
    chk("drain.empty", int'(empty), 1);
    step(1'b0, 1'b1, 1'b0, "drain.extra");
    chk("drain.extra_out", int'(out_address), 0);
    chk("drain.extra_udf", int'(underflow), 1);

    step(1'b0, 1'b0, 1'b1, "flush_a");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, "to5");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, $sformatf("simul%0d", i));
    chk("simul.count", int'(count), 5);
    chk("simul.in", int'(in_address), 11);
    chk("simul.out", int'(out_address), 6);

    // Reach count 7 with overflow set, then flush alongside a write.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, "tofull");
    step(1'b1, 1'b0, 1'b0, "ovf");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, "to7");
    chk("pre_flush.count", int'(count), 7);
    chk("pre_flush.ovf", int'(overflow), 1);
    step(1'b1, 1'b0, 1'b1, "flush_we");
    chk_all("flush_we.const", z);

    // Asynchronous reset lands between edges.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "pre_async");
    #2 reset = 1'b1;
    #1;
    chk_all("async_reset", z);
    @(posedge clk); #1 reset = 1'b0;
    model_clear();
    step(1'b1, 1'b0, 1'b0, "post_async");

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("d16.pre_in%0d", i), int'(in_address16), i);
      write_en16 = 1'b1;
      @(posedge clk); #1;
      write_en16 = 1'b0;
      chk($sformatf("d16.count%0d", i), int'(count16), i + 1);
    end
    chk("d16.full", int'(full16), 1);
    chk("d16.in_wrap", int'(in_address16), 0);
    write_en16 = 1'b1;
    @(posedge clk); #1;
    write_en16 = 1'b0;
    chk("d16.ovf", int'(ovf16), 1);
    chk("d16.count_hold", int'(count16), 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
